// File: rtl/lsu_dccm_arb.sv
// Single-slot DCCM arbiter: LSU reads, store-buffer drains and DMA share one access per cycle.
// Optional starvation override is compiled in with `define RV_DCCM_ARB_STARVE_EN.
module lsu_dccm_arb #(
    parameter int DCCM_BITS        = 16,
    parameter int DCCM_FDATA_WIDTH = 39,
    parameter int STARVE_MAX       = 15,
    parameter int STARVE_CNT_W     = 4
) (
    input  logic                        clk,
    input  logic                        rst_l,

    input  logic                        lsu_rd_req,
    input  logic [DCCM_BITS-1:0]        lsu_rd_addr_lo,
    input  logic [DCCM_BITS-1:0]        lsu_rd_addr_hi,
    output logic                        lsu_rd_gnt,
    output logic                        lsu_rd_valid,

    input  logic                        stb_wr_req,
    input  logic [DCCM_BITS-1:0]        stb_wr_addr_lo,
    input  logic [DCCM_BITS-1:0]        stb_wr_addr_hi,
    input  logic [DCCM_FDATA_WIDTH-1:0] stb_wr_data_lo,
    input  logic [DCCM_FDATA_WIDTH-1:0] stb_wr_data_hi,
    output logic                        stb_wr_gnt,

    input  logic                        dma_req,
    input  logic                        dma_write,
    input  logic [DCCM_BITS-1:0]        dma_addr,
    input  logic [DCCM_FDATA_WIDTH-1:0] dma_wdata,
    output logic                        dma_gnt,
    output logic                        dma_rd_valid,

    output logic                        dccm_wren,
    output logic                        dccm_rden,
    output logic [DCCM_BITS-1:0]        dccm_wr_addr_lo,
    output logic [DCCM_BITS-1:0]        dccm_wr_addr_hi,
    output logic [DCCM_BITS-1:0]        dccm_rd_addr_lo,
    output logic [DCCM_BITS-1:0]        dccm_rd_addr_hi,
    output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_lo,
    output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_hi,
    input  logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_lo,
    input  logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_hi,
    output logic [DCCM_FDATA_WIDTH-1:0] rd_data_lo,
    output logic [DCCM_FDATA_WIDTH-1:0] rd_data_hi
);

    // Handshake: req is a level held with stable operands until the same-cycle
    // combinational gnt; the transfer happens in the gnt cycle, and a requester
    // may present a new request (or drop req) in the following cycle.

    logic rr_q;          // 0: STB preferred over DMA, 1: DMA preferred
    logic rsp_lsu_q;
    logic rsp_dma_q;
    logic stb_starved;
    logic dma_starved;
    logic lsu_pick;
    logic stb_pick;
    logic dma_pick;
    logic dma_rd_gnt;
    logic dma_wr_gnt;

`ifdef RV_DCCM_ARB_STARVE_EN
    localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

    logic [STARVE_CNT_W-1:0] stb_wait_q;
    logic [STARVE_CNT_W-1:0] dma_wait_q;

    // Wait counters only run while a request is pending and losing; they saturate at the limit.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            stb_wait_q <= '0;
            dma_wait_q <= '0;
        end else begin
            if (!stb_wr_req || stb_wr_gnt)
                stb_wait_q <= '0;
            else if (stb_wait_q != STARVE_LIM)
                stb_wait_q <= stb_wait_q + 1'b1;

            if (!dma_req || dma_gnt)
                dma_wait_q <= '0;
            else if (dma_wait_q != STARVE_LIM)
                dma_wait_q <= dma_wait_q + 1'b1;
        end
    end

    // Qualify with req: a counter still at the limit the cycle req drops must not win.
    assign stb_starved = stb_wr_req && (stb_wait_q == STARVE_LIM);
    assign dma_starved = dma_req    && (dma_wait_q == STARVE_LIM);
`else
    logic [STARVE_CNT_W-1:0] starve_lim_unused;
    assign starve_lim_unused = STARVE_CNT_W'(STARVE_MAX);
    assign stb_starved = 1'b0;
    assign dma_starved = 1'b0;
`endif

    always_comb begin
        lsu_pick = 1'b0;
        stb_pick = 1'b0;
        dma_pick = 1'b0;
        if (stb_starved && dma_starved) begin
            if (rr_q) dma_pick = 1'b1;
            else      stb_pick = 1'b1;
        end else if (stb_starved) begin
            stb_pick = 1'b1;
        end else if (dma_starved) begin
            dma_pick = 1'b1;
        end else if (lsu_rd_req) begin
            lsu_pick = 1'b1;
        end else if (stb_wr_req && dma_req) begin
            if (rr_q) dma_pick = 1'b1;
            else      stb_pick = 1'b1;
        end else if (stb_wr_req) begin
            stb_pick = 1'b1;
        end else if (dma_req) begin
            dma_pick = 1'b1;
        end
    end

    // Grants are forced low while reset is asserted, even though requests may be present.
    assign lsu_rd_gnt = lsu_pick & rst_l;
    assign stb_wr_gnt = stb_pick & rst_l;
    assign dma_gnt    = dma_pick & rst_l;
    assign dma_rd_gnt = dma_gnt & ~dma_write;
    assign dma_wr_gnt = dma_gnt &  dma_write;

    assign dccm_rden = lsu_rd_gnt | dma_rd_gnt;
    assign dccm_wren = stb_wr_gnt | dma_wr_gnt;

    always_comb begin
        dccm_rd_addr_lo = '0;
        dccm_rd_addr_hi = '0;
        dccm_wr_addr_lo = '0;
        dccm_wr_addr_hi = '0;
        dccm_wr_data_lo = '0;
        dccm_wr_data_hi = '0;
        if (lsu_rd_gnt) begin
            dccm_rd_addr_lo = lsu_rd_addr_lo;
            dccm_rd_addr_hi = lsu_rd_addr_hi;
        end else if (dma_rd_gnt) begin
            dccm_rd_addr_lo = dma_addr;
            dccm_rd_addr_hi = dma_addr;
        end
        if (stb_wr_gnt) begin
            dccm_wr_addr_lo = stb_wr_addr_lo;
            dccm_wr_addr_hi = stb_wr_addr_hi;
            dccm_wr_data_lo = stb_wr_data_lo;
            dccm_wr_data_hi = stb_wr_data_hi;
        end else if (dma_wr_gnt) begin
            dccm_wr_addr_lo = dma_addr;
            dccm_wr_addr_hi = dma_addr;
            dccm_wr_data_lo = dma_wdata;
            dccm_wr_data_hi = dma_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rr_q      <= 1'b0;
            rsp_lsu_q <= 1'b0;
            rsp_dma_q <= 1'b0;
        end else begin
            if (stb_wr_gnt)
                rr_q <= 1'b1;
            else if (dma_gnt)
                rr_q <= 1'b0;
            rsp_lsu_q <= lsu_rd_gnt;
            rsp_dma_q <= dma_rd_gnt;
        end
    end

    assign lsu_rd_valid = rsp_lsu_q;
    assign dma_rd_valid = rsp_dma_q;
    assign rd_data_lo   = dccm_rd_data_lo;
    assign rd_data_hi   = dccm_rd_data_hi;

endmodule

// File: tb/tb_lsu_dccm_arb.sv
// Bench for lsu_dccm_arb: directed scenarios plus randomized traffic, all outputs compared
// every cycle against a transaction-level priority model.
module tb_lsu_dccm_arb;

    localparam int AW   = 16;
    localparam int DW   = 39;
    localparam int SMAX = 15;
    localparam int W_NONE = 0;
    localparam int W_LSU  = 1;
    localparam int W_STB  = 2;
    localparam int W_DMA  = 3;
`ifdef RV_DCCM_ARB_STARVE_EN
    localparam bit STARVE_EN    = 1'b1;
    localparam int EXP_T5_CYCLE = 16;
`else
    localparam bit STARVE_EN    = 1'b0;
    localparam int EXP_T5_CYCLE = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_l;
    logic          lsu_rd_req;
    logic [AW-1:0] lsu_rd_addr_lo, lsu_rd_addr_hi;
    logic          lsu_rd_gnt, lsu_rd_valid;
    logic          stb_wr_req;
    logic [AW-1:0] stb_wr_addr_lo, stb_wr_addr_hi;
    logic [DW-1:0] stb_wr_data_lo, stb_wr_data_hi;
    logic          stb_wr_gnt;
    logic          dma_req, dma_write;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_gnt, dma_rd_valid;
    logic          dccm_wren, dccm_rden;
    logic [AW-1:0] dccm_wr_addr_lo, dccm_wr_addr_hi, dccm_rd_addr_lo, dccm_rd_addr_hi;
    logic [DW-1:0] dccm_wr_data_lo, dccm_wr_data_hi;
    logic [DW-1:0] dccm_rd_data_lo, dccm_rd_data_hi;
    logic [DW-1:0] rd_data_lo, rd_data_hi;

    lsu_dccm_arb dut (
        .clk(clk), .rst_l(rst_l),
        .lsu_rd_req(lsu_rd_req), .lsu_rd_addr_lo(lsu_rd_addr_lo), .lsu_rd_addr_hi(lsu_rd_addr_hi),
        .lsu_rd_gnt(lsu_rd_gnt), .lsu_rd_valid(lsu_rd_valid),
        .stb_wr_req(stb_wr_req), .stb_wr_addr_lo(stb_wr_addr_lo), .stb_wr_addr_hi(stb_wr_addr_hi),
        .stb_wr_data_lo(stb_wr_data_lo), .stb_wr_data_hi(stb_wr_data_hi), .stb_wr_gnt(stb_wr_gnt),
        .dma_req(dma_req), .dma_write(dma_write), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rd_valid(dma_rd_valid),
        .dccm_wren(dccm_wren), .dccm_rden(dccm_rden),
        .dccm_wr_addr_lo(dccm_wr_addr_lo), .dccm_wr_addr_hi(dccm_wr_addr_hi),
        .dccm_rd_addr_lo(dccm_rd_addr_lo), .dccm_rd_addr_hi(dccm_rd_addr_hi),
        .dccm_wr_data_lo(dccm_wr_data_lo), .dccm_wr_data_hi(dccm_wr_data_hi),
        .dccm_rd_data_lo(dccm_rd_data_lo), .dccm_rd_data_hi(dccm_rd_data_hi),
        .rd_data_lo(rd_data_lo), .rd_data_hi(rd_data_hi)
    );

    // clock
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // model state: who is preferred between STB/DMA, wait counts, outstanding read returns
    bit m_dma_turn;
    int m_stb_wait, m_dma_wait;
    bit m_pend_lsu, m_pend_dma;
    int last_w;

    logic [2:0]    cap_gnt;
    logic          cap_rden, cap_lsu_v, cap_dma_v;
    logic [AW-1:0] cap_rd_lo, cap_rd_hi;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_winner();
        bit stb_st, dma_st;
        stb_st = STARVE_EN && stb_wr_req && (m_stb_wait >= SMAX);
        dma_st = STARVE_EN && dma_req && (m_dma_wait >= SMAX);
        if (!rst_l) return W_NONE;
        if (stb_st && dma_st) return m_dma_turn ? W_DMA : W_STB;
        if (stb_st) return W_STB;
        if (dma_st) return W_DMA;
        if (lsu_rd_req) return W_LSU;
        if (stb_wr_req && dma_req) return m_dma_turn ? W_DMA : W_STB;
        if (stb_wr_req) return W_STB;
        if (dma_req) return W_DMA;
        return W_NONE;
    endfunction

    // One clock: inputs already set just after posedge; compare at negedge; advance model.
    task automatic cycle();
        logic [63:0] r;
        int w;
        bit e_lsu, e_stb, e_dma, e_dr, e_dw;
        logic [AW-1:0] e_rd_lo, e_rd_hi, e_wr_lo, e_wr_hi;
        logic [DW-1:0] e_wd_lo, e_wd_hi;
        r = {$urandom, $urandom};
        dccm_rd_data_lo = r[DW-1:0];
        r = {$urandom, $urandom};
        dccm_rd_data_hi = r[DW-1:0];
        @(negedge clk);
        w = model_winner();
        last_w = w;
        e_lsu = (w == W_LSU);
        e_stb = (w == W_STB);
        e_dma = (w == W_DMA);
        e_dr  = e_dma && !dma_write;
        e_dw  = e_dma && dma_write;
        e_rd_lo = e_lsu ? lsu_rd_addr_lo : (e_dr ? dma_addr : '0);
        e_rd_hi = e_lsu ? lsu_rd_addr_hi : (e_dr ? dma_addr : '0);
        e_wr_lo = e_stb ? stb_wr_addr_lo : (e_dw ? dma_addr : '0);
        e_wr_hi = e_stb ? stb_wr_addr_hi : (e_dw ? dma_addr : '0);
        e_wd_lo = e_stb ? stb_wr_data_lo : (e_dw ? dma_wdata : '0);
        e_wd_hi = e_stb ? stb_wr_data_hi : (e_dw ? dma_wdata : '0);
        if (!rst_l) begin
            m_pend_lsu = 1'b0;
            m_pend_dma = 1'b0;
        end
        chk("lsu_rd_gnt", 64'(lsu_rd_gnt), 64'(e_lsu));
        chk("stb_wr_gnt", 64'(stb_wr_gnt), 64'(e_stb));
        chk("dma_gnt", 64'(dma_gnt), 64'(e_dma));
        chk("dccm_rden", 64'(dccm_rden), 64'(e_lsu || e_dr));
        chk("dccm_wren", 64'(dccm_wren), 64'(e_stb || e_dw));
        chk("dccm_rd_addr_lo", 64'(dccm_rd_addr_lo), 64'(e_rd_lo));
        chk("dccm_rd_addr_hi", 64'(dccm_rd_addr_hi), 64'(e_rd_hi));
        chk("dccm_wr_addr_lo", 64'(dccm_wr_addr_lo), 64'(e_wr_lo));
        chk("dccm_wr_addr_hi", 64'(dccm_wr_addr_hi), 64'(e_wr_hi));
        chk("dccm_wr_data_lo", 64'(dccm_wr_data_lo), 64'(e_wd_lo));
        chk("dccm_wr_data_hi", 64'(dccm_wr_data_hi), 64'(e_wd_hi));
        chk("lsu_rd_valid", 64'(lsu_rd_valid), 64'(m_pend_lsu));
        chk("dma_rd_valid", 64'(dma_rd_valid), 64'(m_pend_dma));
        chk("rd_data_lo", 64'(rd_data_lo), 64'(dccm_rd_data_lo));
        chk("rd_data_hi", 64'(rd_data_hi), 64'(dccm_rd_data_hi));
        cap_gnt   = {lsu_rd_gnt, stb_wr_gnt, dma_gnt};
        cap_rden  = dccm_rden;
        cap_rd_lo = dccm_rd_addr_lo;
        cap_rd_hi = dccm_rd_addr_hi;
        cap_lsu_v = lsu_rd_valid;
        cap_dma_v = dma_rd_valid;
        if (!rst_l) begin
            m_dma_turn = 1'b0;
            m_stb_wait = 0;
            m_dma_wait = 0;
        end else begin
            m_pend_lsu = e_lsu;
            m_pend_dma = e_dr;
            if (e_stb) m_dma_turn = 1'b1;
            if (e_dma) m_dma_turn = 1'b0;
            m_stb_wait = (stb_wr_req && !e_stb) ? ((m_stb_wait < SMAX) ? m_stb_wait + 1 : SMAX) : 0;
            m_dma_wait = (dma_req && !e_dma) ? ((m_dma_wait < SMAX) ? m_dma_wait + 1 : SMAX) : 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic new_stb_ops();
        logic [63:0] r;
        stb_wr_addr_lo = AW'($urandom);
        stb_wr_addr_hi = AW'($urandom);
        r = {$urandom, $urandom};
        stb_wr_data_lo = r[DW-1:0];
        r = {$urandom, $urandom};
        stb_wr_data_hi = r[DW-1:0];
    endtask

    task automatic new_dma_ops(input bit wr);
        logic [63:0] r;
        dma_write = wr;
        dma_addr  = AW'($urandom) & 16'hfff8;
        r = {$urandom, $urandom};
        dma_wdata = r[DW-1:0];
    endtask

    task automatic idle_inputs();
        lsu_rd_req = 1'b0;
        stb_wr_req = 1'b0;
        dma_req    = 1'b0;
    endtask

    initial begin
        int t5_cycle;
        int stb_wins;
        rst_l = 1'b0;
        idle_inputs();
        lsu_rd_addr_lo = '0; lsu_rd_addr_hi = '0;
        new_stb_ops();
        new_dma_ops(1'b0);
        m_dma_turn = 1'b0; m_stb_wait = 0; m_dma_wait = 0;
        m_pend_lsu = 1'b0; m_pend_dma = 1'b0;
        // reset state, with requests present during reset
        #1;
        lsu_rd_req = 1'b1;
        stb_wr_req = 1'b1;
        cycle();
        chk("reset_gnt", 64'(cap_gnt), 64'(3'b000));
        idle_inputs();
        cycle();
        rst_l = 1'b1;
        cycle();

        // single LSU read
        lsu_rd_req = 1'b1; lsu_rd_addr_lo = 16'h0100; lsu_rd_addr_hi = 16'h0104;
        cycle();
        chk("t1_gnt", 64'(cap_gnt), 64'(3'b100));
        chk("t1_rden", 64'(cap_rden), 64'(1));
        chk("t1_rd_addr_lo", 64'(cap_rd_lo), 64'(16'h0100));
        lsu_rd_req = 1'b0;
        cycle();
        chk("t1_lsu_valid", 64'(cap_lsu_v), 64'(1));
        chk("t1_dma_valid", 64'(cap_dma_v), 64'(0));

        // all three request: LSU, then STB, then DMA
        lsu_rd_req = 1'b1; stb_wr_req = 1'b1; new_stb_ops();
        dma_req = 1'b1; new_dma_ops(1'b1);
        cycle();
        chk("t2_first", 64'(cap_gnt), 64'(3'b100));
        lsu_rd_req = 1'b0;
        cycle();
        chk("t2_second", 64'(cap_gnt), 64'(3'b010));
        stb_wr_req = 1'b0;
        cycle();
        chk("t2_third", 64'(cap_gnt), 64'(3'b001));
        dma_req = 1'b0;

        // STB and DMA continuously: strict alternation starting with STB
        stb_wr_req = 1'b1; new_stb_ops();
        dma_req = 1'b1; new_dma_ops(1'b1);
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("t3_alternate", 64'(cap_gnt), (k % 2 == 0) ? 64'(3'b010) : 64'(3'b001));
            if (k >= 4) begin
                if (k == 4) stb_wr_req = 1'b0;
                else dma_req = 1'b0;
            end else if (k % 2 == 0) new_stb_ops();
            else new_dma_ops(1'b1);
        end

        // DMA read
        dma_req = 1'b1; dma_write = 1'b0; dma_addr = 16'h0208;
        cycle();
        chk("t4_rden", 64'(cap_rden), 64'(1));
        chk("t4_rd_addr_lo", 64'(cap_rd_lo), 64'(16'h0208));
        chk("t4_rd_addr_hi", 64'(cap_rd_hi), 64'(16'h0208));
        dma_req = 1'b0;
        cycle();
        chk("t4_dma_valid", 64'(cap_dma_v), 64'(1));
        cycle();
        chk("t4_dma_valid_once", 64'(cap_dma_v), 64'(0));

        // LSU held 20 cycles against a waiting STB drain
        t5_cycle = 0;
        lsu_rd_req = 1'b1; lsu_rd_addr_lo = 16'h0040; lsu_rd_addr_hi = 16'h0044;
        stb_wr_req = 1'b1; new_stb_ops();
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (cap_gnt == 3'b010 && t5_cycle == 0) begin
                t5_cycle = k;
                stb_wr_req = 1'b0;
            end
        end
        chk("t5_stb_gnt_cycle", 64'(t5_cycle), 64'(EXP_T5_CYCLE));
        // a fresh STB request must wait again from zero
        stb_wr_req = 1'b1; new_stb_ops();
        stb_wins = 0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            if (cap_gnt[1]) stb_wins++;
        end
        chk("t5_counter_cleared", 64'(stb_wins), 64'(0));
        lsu_rd_req = 1'b0;
        cycle();
        stb_wr_req = 1'b0;

        // randomized traffic, alternating light and saturating LSU phases
        for (int c = 0; c < 1200; c++) begin
            int lsu_p;
            lsu_p = ((c / 150) % 2 == 1) ? 100 : 35;
            if (last_w == W_LSU || !lsu_rd_req) begin
                lsu_rd_req = ($urandom_range(0, 99) < lsu_p);
                lsu_rd_addr_lo = AW'($urandom);
                lsu_rd_addr_hi = ($urandom_range(0, 3) == 0) ? lsu_rd_addr_lo + 16'd4 : lsu_rd_addr_lo;
            end
            if (last_w == W_STB || !stb_wr_req) begin
                stb_wr_req = ($urandom_range(0, 99) < 50);
                new_stb_ops();
            end
            if (last_w == W_DMA || !dma_req) begin
                dma_req = ($urandom_range(0, 99) < 40);
                new_dma_ops(1'($urandom_range(0, 1)));
            end
            cycle();
        end
        idle_inputs();
        cycle();
        cycle();

        // reset the cycle after a DMA read grant
        dma_req = 1'b1; new_dma_ops(1'b0);
        cycle();
        chk("t6_dma_gnt", 64'(cap_gnt), 64'(3'b001));
        dma_req = 1'b0;
        rst_l = 1'b0;
        cycle();
        chk("t6_valid_in_reset", 64'(cap_dma_v), 64'(0));
        rst_l = 1'b1;
        cycle();
        chk("t6_no_gnt_after", 64'(cap_gnt), 64'(3'b000));
        chk("t6_valid_after", 64'(cap_dma_v), 64'(0));

        // reset returns the STB/DMA preference to STB
        stb_wr_req = 1'b1; new_stb_ops();
        cycle();
        stb_wr_req = 1'b0;
        rst_l = 1'b0;
        cycle();
        rst_l = 1'b1;
        stb_wr_req = 1'b1; new_stb_ops();
        dma_req = 1'b1; new_dma_ops(1'b1);
        cycle();
        chk("t6_rr_reset", 64'(cap_gnt), 64'(3'b010));
        stb_wr_req = 1'b0;
        cycle();
        dma_req = 1'b0;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
